// File: rtl/rv32i_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_mem_arbiter_pkg
// Description : Shared definitions for the RV32I instruction/data memory
//               arbiter. Holds the arbiter state encodings, the fixed
//               instruction-fetch byte enable, the last-grant encoding, the
//               registered master request record and the arbitration helper.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package rv32i_mem_arbiter_pkg;

  // Arbiter state encodings.
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GNT_I = 2'd1;
  localparam logic [1:0] ARB_GNT_D = 2'd2;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] ARB_IBE = 4'hF;

  // Encoding of the last requester that was served.
  localparam logic LG_INSTR = 1'b0;
  localparam logic LG_DATA  = 1'b1;

  // Registered master-side request. Everything driven onto the Avalon
  // master port comes from one of these records so all strobes, address
  // and data move together on the grant edge.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } mreq_t;

  // Returns 1 when the data port should be granted. Only a tie between
  // both requesters consults prefer_data.
  function automatic logic arb_pick_data(input logic ireq,
                                         input logic dreq,
                                         input logic prefer_data);
    logic pick;
    if (ireq && dreq) begin
      pick = prefer_data;
    end else begin
      pick = dreq;
    end
    return pick;
  endfunction

endpackage : rv32i_mem_arbiter_pkg
`default_nettype wire

// File: rtl/rv32i_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_arb_watchdog
// Description : Waitrequest watchdog for the RV32I memory arbiter. Counts
//               consecutive stalled cycles of a granted transfer and raises a
//               single-cycle expire pulse in the cycle the count reaches
//               TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 removes the counter.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               count_en - a granted transfer is stalled this cycle
//               clear    - restart counting from zero
//               expire   - stall limit reached this cycle (pulse)
// Revision    : 1.0  initial release
// ============================================================================
module rv32i_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_BITS   = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdt_on
      // The count lags the stalled cycle by one, so the limit compare is
      // against TIMEOUT_CYCLES-1: expire fires on the TIMEOUT_CYCLES-th
      // consecutive stalled cycle, not the one after it.
      localparam logic [TIMEOUT_BITS-1:0] LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

      logic [TIMEOUT_BITS-1:0] count_q;
      logic [TIMEOUT_BITS-1:0] count_d;
      logic                    at_limit;

      always_comb begin
        at_limit = (count_q == LIMIT);
        count_d  = count_q;
        if (clear || (count_en && at_limit)) begin
          count_d = '0;
        end else if (count_en) begin
          count_d = count_q + TIMEOUT_BITS'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expire = count_en & at_limit;
    end else begin : g_wdt_off
      logic wdt_unused;
      assign wdt_unused = ^{clk, reset_n, count_en, clear};
      assign expire     = 1'b0;
    end
  endgenerate

endmodule : rv32i_arb_watchdog
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_mem_arbiter
// Description : Shares one Avalon-MM style master port between the RV32I
//               instruction-fetch port and data load/store port. Arbitrates
//               per transfer from IDLE, registers the master request, and
//               returns completion combinationally to the granted requester.
//               A waitrequest watchdog aborts hung transfers.
// Build option: RV32I_MEM_ARB_RR_EN - when defined, simultaneous requests are
//               granted round-robin against the last served port and
//               DATA_PRIORITY is ignored; otherwise fixed priority applies.
// Ports       : clk, reset_n            - clock, async active-low reset
//               iaddress/iread          - fetch request
//               ireaddata/iwaitrequest  - fetch response / stall
//               daddress/dwrite/dwritedata/dbyteenable/dread - data request
//               dreaddata/dwaitrequest  - data response / stall
//               m_*                     - shared Avalon-MM master port
//               bus_error               - one-cycle pulse on watchdog abort
// Revision    : 1.0  initial release
// ============================================================================
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_BITS   = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction fetch port
  input  logic [31:0] iaddress,
  input  logic        iread,
  output logic [31:0] ireaddata,
  output logic        iwaitrequest,
  // data load/store port
  input  logic [31:0] daddress,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  input  logic        dread,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  // shared master port
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        bus_error
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_grant_q;
  logic       last_grant_d;
  mreq_t      mreq_q;
  mreq_t      mreq_d;
  logic       bus_error_q;
  logic       bus_error_d;
  logic       abort_i_q;
  logic       abort_i_d;
  logic       abort_d_q;
  logic       abort_d_d;

  logic       dreq;
  logic       prefer_data;
  logic       in_grant;
  logic       abort_pending;
  logic       wdt_count_en;
  logic       wdt_clear;
  logic       wdt_expire;
  logic       i_done;
  logic       d_done;

  assign dreq          = dread | dwrite;
  assign in_grant      = (state_q == ARB_GNT_I) || (state_q == ARB_GNT_D);
  assign abort_pending = abort_i_q | abort_d_q;

  // --------------------------------------------------------------------------
  // Tie-break policy
  // --------------------------------------------------------------------------
`ifdef RV32I_MEM_ARB_RR_EN
  // Favour whichever port was not served last.
  assign prefer_data = (last_grant_q == LG_INSTR);
  logic rr_unused;
  assign rr_unused = (DATA_PRIORITY != 0);
`else
  assign prefer_data = (DATA_PRIORITY != 0);
  logic lg_unused;
  assign lg_unused = last_grant_q;
`endif

  // --------------------------------------------------------------------------
  // Watchdog: counts stalled cycles of the current grant only.
  // --------------------------------------------------------------------------
  assign wdt_count_en = in_grant & m_waitrequest;
  assign wdt_clear    = ~wdt_count_en;

  rv32i_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_BITS   (TIMEOUT_BITS)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .count_en (wdt_count_en),
    .clear    (wdt_clear),
    .expire   (wdt_expire)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= LG_INSTR;
      mreq_q       <= '0;
      bus_error_q  <= 1'b0;
      abort_i_q    <= 1'b0;
      abort_d_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mreq_q       <= mreq_d;
      bus_error_q  <= bus_error_d;
      abort_i_q    <= abort_i_d;
      abort_d_q    <= abort_d_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        // An aborted requester only sees its completion in the IDLE cycle
        // after the abort and is still holding its request then; granting
        // in that cycle would replay the hung transfer.
        if (!abort_pending && (iread || dreq)) begin
          state_d = arb_pick_data(iread, dreq, prefer_data) ? ARB_GNT_D : ARB_GNT_I;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (wdt_expire || !m_waitrequest) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    mreq_d       = mreq_q;
    last_grant_d = last_grant_q;
    bus_error_d  = 1'b0;
    abort_i_d    = 1'b0;
    abort_d_d    = 1'b0;

    if (state_q == ARB_IDLE) begin
      if (state_d == ARB_GNT_I) begin
        mreq_d.addr  = iaddress;
        mreq_d.wdata = '0;
        mreq_d.be    = ARB_IBE;
        mreq_d.rd    = 1'b1;
        mreq_d.wr    = 1'b0;
      end else if (state_d == ARB_GNT_D) begin
        // A store wins if the core raises both strobes together.
        mreq_d.addr  = daddress;
        mreq_d.wdata = dwritedata;
        mreq_d.be    = dbyteenable;
        mreq_d.rd    = dread & ~dwrite;
        mreq_d.wr    = dwrite;
      end
    end else if (state_d == ARB_IDLE) begin
      // Transfer finished or aborted: drop strobes, keep address/data.
      mreq_d.rd    = 1'b0;
      mreq_d.wr    = 1'b0;
      last_grant_d = (state_q == ARB_GNT_D) ? LG_DATA : LG_INSTR;
      if (wdt_expire) begin
        bus_error_d = 1'b1;
        abort_i_d   = (state_q == ARB_GNT_I);
        abort_d_d   = (state_q == ARB_GNT_D);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Requester responses (combinational). An aborted requester completes in
  // the cycle after the abort with zero read data, since state is IDLE then.
  // --------------------------------------------------------------------------
  assign i_done       = ((state_q == ARB_GNT_I) & ~m_waitrequest) | abort_i_q;
  assign d_done       = ((state_q == ARB_GNT_D) & ~m_waitrequest) | abort_d_q;
  assign iwaitrequest = ~i_done;
  assign dwaitrequest = ~d_done;
  assign ireaddata    = (state_q == ARB_GNT_I) ? m_readdata : '0;
  assign dreaddata    = (state_q == ARB_GNT_D) ? m_readdata : '0;

  // --------------------------------------------------------------------------
  // Master port
  // --------------------------------------------------------------------------
  assign m_address    = mreq_q.addr;
  assign m_read       = mreq_q.rd;
  assign m_write      = mreq_q.wr;
  assign m_writedata  = mreq_q.wdata;
  assign m_byteenable = mreq_q.be;
  assign bus_error    = bus_error_q;

endmodule : rv32i_mem_arbiter
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_mem_arbiter
// Description : Self-checking bench for rv32i_mem_arbiter. A slave model
//               with programmable wait states answers the master port; every
//               expected master transfer is queued when stimulus is driven
//               and popped when the slave accepts it. Cycle-level checks
//               cover reset, latency, priority, wait states, the watchdog
//               abort and asynchronous reset. Honours RV32I_MEM_ARB_RR_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

  localparam int TO_CYCLES = 8;
  localparam int WAIT_MAX  = 64;

  logic        clk;
  logic        reset_n;
  logic [31:0] iaddress;
  logic        iread;
  logic [31:0] ireaddata;
  logic        iwaitrequest;
  logic [31:0] daddress;
  logic        dwrite;
  logic [31:0] dwritedata;
  logic [3:0]  dbyteenable;
  logic        dread;
  logic [31:0] dreaddata;
  logic        dwaitrequest;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic        bus_error;

  rv32i_mem_arbiter #(
    .DATA_PRIORITY  (1),
    .TIMEOUT_CYCLES (TO_CYCLES),
    .TIMEOUT_BITS   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .iaddress      (iaddress),
    .iread         (iread),
    .ireaddata     (ireaddata),
    .iwaitrequest  (iwaitrequest),
    .daddress      (daddress),
    .dwrite        (dwrite),
    .dwritedata    (dwritedata),
    .dbyteenable   (dbyteenable),
    .dread         (dread),
    .dreaddata     (dreaddata),
    .dwaitrequest  (dwaitrequest),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .bus_error     (bus_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Slave model
  // --------------------------------------------------------------------------
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    logic [31:0] r;
    if (a == 32'h0000_0100) r = 32'h0000_0013;
    else                    r = a ^ 32'hC0DE_0000;
    return r;
  endfunction

  assign m_readdata = rdata_of(m_address);

  int wait_n = 0;
  bit stuck  = 1'b0;

  initial begin
    int wcnt;
    wcnt = 0;
    m_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_read || m_write) begin
        if (stuck) begin
          m_waitrequest = 1'b1;
        end else if (wcnt < wait_n) begin
          m_waitrequest = 1'b1;
          wcnt++;
        end else begin
          m_waitrequest = 1'b0;
        end
      end else begin
        m_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard: expected master transfers in grant order
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } xfer_t;

  xfer_t sb[$];

  function automatic xfer_t mk(input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] b);
    xfer_t x;
    x.addr = a; x.wr = w; x.wdata = d; x.be = b;
    return x;
  endfunction

  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (m_read || m_write) && !m_waitrequest) begin
        if (sb.size() == 0) begin
          check("sb_underflow", m_address, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_addr", m_address, e.addr);
          check("sb_write", {31'd0, m_write}, {31'd0, e.wr});
          check("sb_read", {31'd0, m_read}, {31'd0, ~e.wr});
          check("sb_be", {28'd0, m_byteenable}, {28'd0, e.be});
          if (e.wr) check("sb_wdata", m_writedata, e.wdata);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [31:0] a;
      a = base + 32'(4 * k);
      iaddress = a;
      iread    = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (iwaitrequest && t < WAIT_MAX);
      if (iwaitrequest) check("fetch_timeout", 32'd1, 32'd0);
      else              check("fetch_rdata", ireaddata, rdata_of(a));
      tick();
    end
    iread = 1'b0;
  endtask

  task automatic load_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      logic [31:0] a;
      a = base + 32'(4 * k);
      daddress    = a;
      dbyteenable = 4'hF;
      dread       = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (dwaitrequest && t < WAIT_MAX);
      if (dwaitrequest) check("load_timeout", 32'd1, 32'd0);
      else              check("load_rdata", dreaddata, rdata_of(a));
      tick();
    end
    dread = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    reset_n     = 1'b0;
    iaddress    = '0;
    iread       = 1'b0;
    daddress    = '0;
    dwrite      = 1'b0;
    dwritedata  = '0;
    dbyteenable = '0;
    dread       = 1'b0;

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_read", {31'd0, m_read}, 32'd0);
    check("rst_m_write", {31'd0, m_write}, 32'd0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_m_be", {28'd0, m_byteenable}, 32'd0);
    check("rst_iwait", {31'd0, iwaitrequest}, 32'd1);
    check("rst_dwait", {31'd0, dwaitrequest}, 32'd1);
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    check("idle_iwait", {31'd0, iwaitrequest}, 32'd1);
    check("idle_dwait", {31'd0, dwaitrequest}, 32'd1);

    // ---- single fetch, zero-wait slave
    tick();
    sb.push_back(mk(32'h100, 1'b0, 32'h0, 4'hF));
    iaddress = 32'h100;
    iread    = 1'b1;
    @(negedge clk);
    check("f_n_m_read", {31'd0, m_read}, 32'd0);
    check("f_n_iwait", {31'd0, iwaitrequest}, 32'd1);
    tick();
    @(negedge clk);
    check("f_n1_m_read", {31'd0, m_read}, 32'd1);
    check("f_n1_addr", m_address, 32'h100);
    check("f_n1_iwait", {31'd0, iwaitrequest}, 32'd0);
    check("f_n1_rdata", ireaddata, 32'h13);
    tick();
    iread = 1'b0;
    @(negedge clk);
    check("f_n2_m_read", {31'd0, m_read}, 32'd0);
    check("f_n2_iwait", {31'd0, iwaitrequest}, 32'd1);

    // ---- simultaneous requests: data first (priority, and round-robin
    //      after an instruction grant), then the fetch
    tick();
    sb.push_back(mk(32'h2000, 1'b0, 32'h0, 4'hF));
    sb.push_back(mk(32'h0, 1'b0, 32'h0, 4'hF));
    iaddress    = 32'h0;
    iread       = 1'b1;
    daddress    = 32'h2000;
    dbyteenable = 4'hF;
    dread       = 1'b1;
    tick();
    @(negedge clk);
    check("sim_addr1", m_address, 32'h2000);
    check("sim_dwait1", {31'd0, dwaitrequest}, 32'd0);
    check("sim_iwait1", {31'd0, iwaitrequest}, 32'd1);
    check("sim_drdata", dreaddata, rdata_of(32'h2000));
    check("sim_irdata_ungranted", ireaddata, 32'd0);
    tick();
    dread = 1'b0;
    @(negedge clk);
    check("sim_iwait2", {31'd0, iwaitrequest}, 32'd1);
    tick();
    @(negedge clk);
    check("sim_addr2", m_address, 32'h0);
    check("sim_iwait3", {31'd0, iwaitrequest}, 32'd0);
    check("sim_irdata", ireaddata, rdata_of(32'h0));
    tick();
    iread = 1'b0;

    // ---- store with three slave wait states
    wait_n = 3;
    sb.push_back(mk(32'h40, 1'b1, 32'hDEAD_BEEF, 4'b0011));
    daddress    = 32'h40;
    dwritedata  = 32'hDEAD_BEEF;
    dbyteenable = 4'b0011;
    dwrite      = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      check("st_m_write", {31'd0, m_write}, 32'd1);
      check("st_addr", m_address, 32'h40);
      check("st_wdata", m_writedata, 32'hDEAD_BEEF);
      check("st_be", {28'd0, m_byteenable}, 32'h3);
      check("st_dwait", {31'd0, dwaitrequest}, (k == 4) ? 32'd0 : 32'd1);
    end
    tick();
    dwrite = 1'b0;
    wait_n = 0;
    @(negedge clk);
    check("st_done_m_write", {31'd0, m_write}, 32'd0);

    // ---- watchdog: slave stuck in waitrequest
    tick();
    stuck       = 1'b1;
    daddress    = 32'h80;
    dbyteenable = 4'hF;
    dread       = 1'b1;
    for (int k = 1; k <= TO_CYCLES; k++) begin
      tick();
      @(negedge clk);
      check("wd_bus_error_low", {31'd0, bus_error}, 32'd0);
      check("wd_dwait_high", {31'd0, dwaitrequest}, 32'd1);
      check("wd_m_read_held", {31'd0, m_read}, 32'd1);
    end
    tick();
    @(negedge clk);
    check("wd_bus_error", {31'd0, bus_error}, 32'd1);
    check("wd_dwait", {31'd0, dwaitrequest}, 32'd0);
    check("wd_drdata", dreaddata, 32'd0);
    check("wd_m_read", {31'd0, m_read}, 32'd0);
    tick();
    dread = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    check("wd_after_bus_error", {31'd0, bus_error}, 32'd0);
    check("wd_after_dwait", {31'd0, dwaitrequest}, 32'd1);
    check("wd_after_m_read", {31'd0, m_read}, 32'd0);

    // ---- asynchronous reset in the middle of a data grant
    tick();
    wait_n   = 5;
    daddress = 32'h300;
    dread    = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("ar_m_read_before", {31'd0, m_read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_m_read", {31'd0, m_read}, 32'd0);
    check("ar_m_write", {31'd0, m_write}, 32'd0);
    check("ar_iwait", {31'd0, iwaitrequest}, 32'd1);
    check("ar_dwait", {31'd0, dwaitrequest}, 32'd1);
    dread  = 1'b0;
    wait_n = 0;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    sb.push_back(mk(32'h200, 1'b0, 32'h0, 4'hF));
    fetch_seq(32'h200, 1);

    // ---- both ports requesting continuously, four transfers each
    tick();
`ifdef RV32I_MEM_ARB_RR_EN
    // Last grant was the fetch above, so data goes first and then they alternate.
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(32'h1000 + 32'(4 * k), 1'b0, 32'h0, 4'hF));
      sb.push_back(mk(32'h4000 + 32'(4 * k), 1'b0, 32'h0, 4'hF));
    end
`else
    for (int k = 0; k < 4; k++) sb.push_back(mk(32'h1000 + 32'(4 * k), 1'b0, 32'h0, 4'hF));
    for (int k = 0; k < 4; k++) sb.push_back(mk(32'h4000 + 32'(4 * k), 1'b0, 32'h0, 4'hF));
`endif
    fork
      fetch_seq(32'h4000, 4);
      load_seq(32'h1000, 4);
    join
    repeat (2) tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule : tb_rv32i_mem_arbiter
`default_nettype wire
